// File: rtl/data_ram.sv
// data_ram: single-port 32-bit word memory with a wait-state access FSM
// (IDLE -> WAIT -> ACK), serving a CPU MEM stage.
//
// A request is latched in IDLE when ce_i is high. The access happens
// WAIT_CYCLES edges after the accept edge, and ack_o pulses in the following
// cycle. With WAIT_CYCLES = 0 the access happens on the accept edge itself.
//
// Parameters:
//   ADDR_WIDTH  - word-address width; depth is 2**ADDR_WIDTH words
//   WAIT_CYCLES - wait states before ack (0..7)
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active low
//   ce_i   - request valid
//   we_i   - 1 = write, 0 = read
//   addr_i - byte address; word index is addr_i[ADDR_WIDTH+1:2]
//   sel_i  - byte-lane enables, sel_i[3] -> data[31:24] (big-endian lane 0)
//   data_i - write data
//   data_o - registered read data, held until the next read completes
//   ack_o  - one-cycle completion pulse
//   busy_o - high whenever the FSM is not idle
//   err_o  - only with DATA_RAM_ERR_EN: pulses with ack_o for an out-of-range
//            address or a write with sel_i = 0
//
// Optional feature macro: DATA_RAM_ERR_EN (error reporting; erroring writes do
// not modify memory, erroring reads return zero). Without it, high address
// bits are ignored and the address wraps modulo the depth.
module data_ram #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        busy_o
`ifdef DATA_RAM_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [2:0] CntInit = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_we_q;
  logic [3:0]            req_sel_q;
  logic [31:0]           req_data_q;
  logic                  req_err_q;

  logic [31:0] mem [Depth];

  logic                  accept;
  logic                  in_err;
  logic                  do_access;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_we;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_data;
  logic                  acc_err;
  logic                  unused_addr_bits;

  assign accept = (state_q == StIdle) && ce_i;

`ifdef DATA_RAM_ERR_EN
  assign in_err = ((addr_i >> (ADDR_WIDTH + 2)) != 32'd0) || (we_i && (sel_i == 4'b0000));
`else
  assign in_err = 1'b0;
`endif

  // Byte-offset bits never matter; high bits only matter for error reporting.
  assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // Access source: with zero wait states the access is done on the accept
  // edge straight from the inputs; otherwise from the latched request.
  always_comb begin
    do_access = 1'b0;
    acc_addr  = req_addr_q;
    acc_we    = req_we_q;
    acc_sel   = req_sel_q;
    acc_data  = req_data_q;
    acc_err   = req_err_q;
    case (state_q)
      StIdle: begin
        if (ce_i && (WAIT_CYCLES == 0)) begin
          do_access = 1'b1;
          acc_addr  = addr_i[ADDR_WIDTH+1:2];
          acc_we    = we_i;
          acc_sel   = sel_i;
          acc_data  = data_i;
          acc_err   = in_err;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) do_access = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (ce_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StAck;
        else cnt_d = cnt_q - 3'd1;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory writes share this process so nothing can be written while reset is
  // held; the reset branch deliberately leaves the array contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      req_addr_q <= '0;
      req_we_q   <= 1'b0;
      req_sel_q  <= 4'b0000;
      req_data_q <= 32'h0;
      req_err_q  <= 1'b0;
      data_o     <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_addr_q <= addr_i[ADDR_WIDTH+1:2];
        req_we_q   <= we_i;
        req_sel_q  <= sel_i;
        req_data_q <= data_i;
        req_err_q  <= in_err;
      end
      if (do_access) begin
        if (acc_we) begin
          if (!acc_err) begin
            for (int b = 0; b < 4; b++) begin
              if (acc_sel[b]) mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
            end
          end
        end else begin
          data_o <= acc_err ? 32'h0 : mem[acc_addr];
        end
      end
    end
  end

  assign ack_o  = (state_q == StAck);
  assign busy_o = (state_q != StIdle);

`ifdef DATA_RAM_ERR_EN
  assign err_o = (state_q == StAck) && req_err_q;
`endif

endmodule
